// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 decoder: tracks make/break/extended prefixes and
// the shift key, translates printable keys to ASCII, and buffers them in an
// 8-entry FIFO that the CPU reads through a memory-mapped register.
module ps2_scancode_decoder #(
  parameter logic [13:0] KEY_ADDRESS = 14'h2501
) (
  input  logic        system_clk,
  input  logic        reset,
  input  logic        scan_valid,
  input  logic [7:0]  scan_code,
  input  logic [13:0] address,
  input  logic        read_strobe,
  output logic [63:0] data
);

  localparam int unsigned FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } state_t;

  state_t      state, next_state;
  logic        shift, next_shift;
  logic        overflow;
  logic [3:0]  count;
  logic [2:0]  wr_ptr, rd_ptr;
  logic [7:0]  mem [FIFO_DEPTH];

  logic        push_req;
  logic [7:0]  push_char;
  logic        hit, rd, pop, fifo_full, push_ok, ovf_set;
  logic [7:0]  head;
  logic [8:0]  xlat;

  // Bit 8 flags a valid translation; bits 7:0 carry the ASCII character.
  function automatic logic [8:0] translate(input logic [7:0] code, input logic sh);
    logic [4:0] idx;
    logic       is_letter;
    logic [8:0] r;
    idx       = '0;
    is_letter = 1'b0;
    r         = '0;
    case (code)
      8'h1C: begin is_letter = 1'b1; idx = 5'd0;  end
      8'h32: begin is_letter = 1'b1; idx = 5'd1;  end
      8'h21: begin is_letter = 1'b1; idx = 5'd2;  end
      8'h23: begin is_letter = 1'b1; idx = 5'd3;  end
      8'h24: begin is_letter = 1'b1; idx = 5'd4;  end
      8'h2B: begin is_letter = 1'b1; idx = 5'd5;  end
      8'h34: begin is_letter = 1'b1; idx = 5'd6;  end
      8'h33: begin is_letter = 1'b1; idx = 5'd7;  end
      8'h43: begin is_letter = 1'b1; idx = 5'd8;  end
      8'h3B: begin is_letter = 1'b1; idx = 5'd9;  end
      8'h42: begin is_letter = 1'b1; idx = 5'd10; end
      8'h4B: begin is_letter = 1'b1; idx = 5'd11; end
      8'h3A: begin is_letter = 1'b1; idx = 5'd12; end
      8'h31: begin is_letter = 1'b1; idx = 5'd13; end
      8'h44: begin is_letter = 1'b1; idx = 5'd14; end
      8'h4D: begin is_letter = 1'b1; idx = 5'd15; end
      8'h15: begin is_letter = 1'b1; idx = 5'd16; end
      8'h2D: begin is_letter = 1'b1; idx = 5'd17; end
      8'h1B: begin is_letter = 1'b1; idx = 5'd18; end
      8'h2C: begin is_letter = 1'b1; idx = 5'd19; end
      8'h3C: begin is_letter = 1'b1; idx = 5'd20; end
      8'h2A: begin is_letter = 1'b1; idx = 5'd21; end
      8'h1D: begin is_letter = 1'b1; idx = 5'd22; end
      8'h22: begin is_letter = 1'b1; idx = 5'd23; end
      8'h35: begin is_letter = 1'b1; idx = 5'd24; end
      8'h1A: begin is_letter = 1'b1; idx = 5'd25; end
      8'h45: r = {1'b1, 8'h30};
      8'h16: r = {1'b1, 8'h31};
      8'h1E: r = {1'b1, 8'h32};
      8'h26: r = {1'b1, 8'h33};
      8'h25: r = {1'b1, 8'h34};
      8'h2E: r = {1'b1, 8'h35};
      8'h36: r = {1'b1, 8'h36};
      8'h3D: r = {1'b1, 8'h37};
      8'h3E: r = {1'b1, 8'h38};
      8'h46: r = {1'b1, 8'h39};
      8'h29: r = {1'b1, 8'h20};
      8'h5A: r = {1'b1, 8'h0D};
      8'h66: r = {1'b1, 8'h08};
      default: r = '0;
    endcase
    if (is_letter)
      r = {1'b1, (sh ? 8'h41 : 8'h61) + {3'b000, idx}};
    return r;
  endfunction

  assign xlat = translate(scan_code, shift);

  // Prefix/shift tracking and translation request for the current byte.
  always_comb begin
    next_state = state;
    next_shift = shift;
    push_req   = 1'b0;
    push_char  = xlat[7:0];
    case (state)
      IDLE: begin
        if (scan_code == 8'hF0)
          next_state = BREAK;
        else if (scan_code == 8'hE0)
          next_state = EXT;
        else if (scan_code == 8'h12 || scan_code == 8'h59)
          next_shift = 1'b1;
        else
          push_req = xlat[8];
      end
      BREAK: begin
        if (scan_code == 8'h12 || scan_code == 8'h59)
          next_shift = 1'b0;
        next_state = IDLE;
      end
      EXT: begin
        next_state = (scan_code == 8'hF0) ? EXT_BREAK : IDLE;
      end
      EXT_BREAK: next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // FIFO control: a pop only happens with data present, so a same-cycle
  // push at count 8 together with a pop is never an overflow.
  always_comb begin
    hit       = (address == KEY_ADDRESS);
    rd        = read_strobe && hit;
    pop       = rd && (count != 4'd0);
    fifo_full = (count == 4'(FIFO_DEPTH));
    push_ok   = scan_valid && push_req && (!fifo_full || pop);
    ovf_set   = scan_valid && push_req && fifo_full && !pop;
    head      = (count == 4'd0) ? 8'h00 : mem[rd_ptr];
  end

  // Control state: FSM, shift, pointers, count, overflow flag.
  always_ff @(posedge system_clk) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= 1'b0;
      overflow <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (scan_valid) begin
        state <= next_state;
        shift <= next_shift;
      end
      if (push_ok) wr_ptr <= wr_ptr + 3'd1;
      if (pop)     rd_ptr <= rd_ptr + 3'd1;
      case ({push_ok, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (ovf_set)
        overflow <= 1'b1;
      else if (rd)
        overflow <= 1'b0;
    end
  end

  // Character storage; contents need no reset.
  always_ff @(posedge system_clk) begin
    if (!reset && push_ok)
      mem[wr_ptr] <= push_char;
  end

  assign data = hit ? {{50{1'b0}}, shift, overflow, count, head} : {64{1'bz}};

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected characters are queued
// as keys are sent; a monitor checks each popped head against the queue.
module tb_ps2_scancode_decoder;

  localparam logic [13:0] KEY = 14'h2501;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_valid;
  logic [7:0]  scan_code;
  logic [13:0] address;
  logic        read_strobe;
  wire  [63:0] data;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [7:0]  exp_q [$];

  ps2_scancode_decoder #(.KEY_ADDRESS(KEY)) dut (
    .system_clk (clk),
    .reset      (reset),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .address    (address),
    .read_strobe(read_strobe),
    .data       (data)
  );

  always #5 clk = ~clk;

  // Monitor: any read at the key address with data present pops the head.
  always @(negedge clk) begin
    logic [7:0] e;
    if (read_strobe === 1'b1 && address == KEY && data[11:8] != 4'd0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got head %h, required no data", data[7:0]);
      end else begin
        e = exp_q.pop_front();
        if (data[7:0] !== e) begin
          fails++;
          $display("FAIL pop_head: got %h, required %h", data[7:0], e);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Send one byte; exp_valid queues the character it should produce.
  task automatic send(input logic [7:0] code, input logic exp_valid, input logic [7:0] exp_ch);
    scan_valid = 1'b1;
    scan_code  = code;
    if (exp_valid) exp_q.push_back(exp_ch);
    cycle();
    scan_valid = 1'b0;
  endtask

  task automatic read_once();
    read_strobe = 1'b1;
    cycle();
    read_strobe = 1'b0;
  endtask

  task automatic drain(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) read_once();
  endtask

  task automatic check_reg(input string name, input logic sh, input logic ovf,
                           input logic [3:0] cnt, input logic [7:0] hd);
    logic [63:0] e;
    e = {{50{1'b0}}, sh, ovf, cnt, hd};
    tests++;
    if (data !== e) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, data, e);
    end
  endtask

  initial begin
    reset = 1'b1; scan_valid = 1'b0; scan_code = '0;
    address = KEY; read_strobe = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    check_reg("reset_image", 1'b0, 1'b0, 4'd0, 8'h00);

    // Lower/upper case with shift make and break
    send(8'h1C, 1, 8'h61); send(8'h12, 0, 8'h00); send(8'h1C, 1, 8'h41);
    send(8'h F0, 0, 8'h00); send(8'h12, 0, 8'h00); send(8'h1C, 1, 8'h61);
    check_reg("case_seq", 1'b0, 1'b0, 4'd3, 8'h61);
    drain(3);
    check_reg("case_drained", 1'b0, 1'b0, 4'd0, 8'h00);

    // Break code suppression
    send(8'h32, 1, 8'h62); send(8'hF0, 0, 8'h00); send(8'h32, 0, 8'h00);
    check_reg("break_suppress", 1'b0, 1'b0, 4'd1, 8'h62);
    drain(1);

    // Extended keys ignored; FSM back in IDLE afterwards
    send(8'hE0, 0, 8'h00); send(8'h75, 0, 8'h00);
    send(8'hE0, 0, 8'h00); send(8'hF0, 0, 8'h00); send(8'h75, 0, 8'h00);
    check_reg("ext_ignored", 1'b0, 1'b0, 4'd0, 8'h00);
    send(8'h1C, 1, 8'h61);
    check_reg("ext_idle", 1'b0, 1'b0, 4'd1, 8'h61);
    drain(1);

    // Digits, specials, unmapped code, right shift
    send(8'h45, 1, 8'h30); send(8'h29, 1, 8'h20); send(8'h5A, 1, 8'h0D);
    send(8'h66, 1, 8'h08); send(8'h1A, 1, 8'h7A); send(8'h76, 0, 8'h00);
    send(8'h59, 0, 8'h00); send(8'h15, 1, 8'h51); send(8'h46, 1, 8'h39);
    check_reg("misc_shifted", 1'b1, 1'b0, 4'd7, 8'h30);
    send(8'hF0, 0, 8'h00); send(8'h59, 0, 8'h00); send(8'h4D, 1, 8'h70);
    check_reg("misc_unshift", 1'b0, 1'b0, 4'd8, 8'h30);
    drain(8);

    // Overflow: ninth press dropped, first read clears the flag
    for (int unsigned i = 0; i < 9; i++) send(8'h16, (i < 8), 8'h31);
    check_reg("ovf_full", 1'b0, 1'b1, 4'd8, 8'h31);
    read_once();
    check_reg("ovf_cleared", 1'b0, 1'b0, 4'd7, 8'h31);
    drain(7);

    // Simultaneous push and pop at count 2
    send(8'h1C, 1, 8'h61); send(8'h32, 1, 8'h62);
    read_strobe = 1'b1;
    send(8'h29, 1, 8'h20);
    read_strobe = 1'b0;
    check_reg("pushpop_cnt2", 1'b0, 1'b0, 4'd2, 8'h62);
    read_once();
    check_reg("pushpop_tail", 1'b0, 1'b0, 4'd1, 8'h20);
    read_once();

    // Push with read at count 0: pop ignored
    read_strobe = 1'b1;
    send(8'h21, 1, 8'h63);
    read_strobe = 1'b0;
    check_reg("pushpop_empty", 1'b0, 1'b0, 4'd1, 8'h63);

    // Ten push/pop pairs walk the pointers around the ring
    for (int unsigned i = 0; i < 10; i++) begin
      read_strobe = 1'b1;
      send(8'h24, 1, 8'h65);
    end
    read_strobe = 1'b0;
    check_reg("wrap_pairs", 1'b0, 1'b0, 4'd1, 8'h65);
    drain(1);

    // Reset priority over a simultaneous key
    reset = 1'b1;
    send(8'h1C, 0, 8'h00);
    reset = 1'b0;
    check_reg("reset_priority", 1'b0, 1'b0, 4'd0, 8'h00);

    // Mid-sequence reset abandons the pending break
    send(8'hF0, 0, 8'h00);
    reset = 1'b1; cycle(); reset = 1'b0;
    send(8'h1C, 1, 8'h61);
    check_reg("midseq_reset", 1'b0, 1'b0, 4'd1, 8'h61);

    // Off-address: bus released (2-state simulators resolve it to 0)
    address = 14'h0123;
    #1;
    tests++;
    if (!(data === {64{1'bz}} || data === 64'h0)) begin
      fails++;
      $display("FAIL off_address: got %h, required all Z", data);
    end
    address = KEY;
    drain(1);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty: got %0d pending, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
